mosaic_ctrl: RTL and testbench
==============================

# mosaic_ctrl

Sequencing and configuration controller for the PPU BG mosaic counter block. It decodes the PPU dot/line position into the `newframe`, `newline` and `period_start` strobes the mosaic counter consumes, and shadows the MOSAIC register (size and per-BG enable). Mid-line register writes are deferred so that size and enable never change inside the active display window. It sits between the CPU-side PPU register decoder/timing generator and the mosaic counter plus the four BG fetch units.

## Interface
- H_ACT_START, 22: h_ctr of the first active pixel.
- H_ACT_END, 277: h_ctr of the last active pixel.
- H_TOTAL, 340: dots per line; h_ctr runs 0..H_TOTAL-1.
- V_ACT_START, 1: first active line.
- V_LAST_SHORT, 224: last active line when overscan=0.
- V_LAST_LONG, 239: last active line when overscan=1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- dot_en  in  1  dot enable; all state and outputs advance only on dot_en, except write capture.
- h_ctr  in  9  current dot.
- v_ctr  in  9  current line.
- overscan  in  1  selects the last active line.
- reg_wr  in  1  single-clk MOSAIC write strobe; need not coincide with dot_en.
- reg_data  in  8  write data: [7:4] size, [3:0] BG1..BG4 enable.
- newframe  out  1  registered strobe to the mosaic counter.
- newline  out  1  registered strobe to the mosaic counter.
- period_start  out  1  registered strobe to the mosaic counter.
- size  out  4  applied mosaic size (block width/height minus 1).
- bg_en  out  4  applied per-BG mosaic enable.
- active  out  1  registered; high while the output dot is in the active window.
- pend  out  1  a write is captured but not yet applied.

## Operation
- FSM has three states: VBLANK, HBLANK, ACTIVE. Reset state is VBLANK.
- All transitions and strobe computations use the h_ctr/v_ctr values sampled on a dot_en cycle.
- Output registers load on that same dot_en cycle. They are therefore visible during the next dot, which is when the mosaic counter samples them.

Strobe conditions (each output is 1 for exactly one dot; otherwise 0):
- newframe: v_ctr==V_ACT_START-1 and h_ctr==H_TOTAL-1.
  - The FSM goes VBLANK→HBLANK.
  - overscan is latched as v_last for the whole frame.
- newline: h_ctr==H_TOTAL-1 and V_ACT_START ≤ v_ctr < v_last.
- period_start: state HBLANK, V_ACT_START ≤ v_ctr ≤ v_last, and h_ctr==H_ACT_START-2.
  - The mosaic x counter is therefore 0 on the first active pixel.

Other transitions:
- HBLANK→ACTIVE when h_ctr==H_ACT_START-1 on an active line. The active register is loaded with 1 on this dot.
- ACTIVE→HBLANK when h_ctr==H_ACT_END. active is loaded with 0.
- HBLANK→VBLANK when h_ctr==H_TOTAL-1 and v_ctr==v_last.

Register writes:
- reg_wr on any clk copies reg_data into the pending registers and sets pend.
- Apply happens on a dot_en cycle with pend=1 whose current state is VBLANK or HBLANK. On apply: size and bg_en take the pending value, and pend clears.
- Writes during ACTIVE are held. The first eligible apply is the dot_en cycle of the ACTIVE→HBLANK transition, so the new value is visible from dot H_ACT_END+1.
- Multiple writes before apply: the last write wins.
- reg_wr on the same clk as an apply: reg_data bypasses directly into size/bg_en and pend ends at 0.

Reset:
- Clears all outputs (including size, bg_en and pend) to 0, and also clears the pending data and v_last.
- Reset mid-frame: the FSM stays in VBLANK until the next newframe condition. No newline or period_start is issued before then.

## Timing
- Strobe latency: 1 dot after the decoded position. Without a dot_en the outputs hold their value.
- Write latency:
  - VBLANK/HBLANK: applied on the next dot_en.
  - ACTIVE: applied at the H_ACT_END dot.
- v_ctr outside 0..v_last, other than the VBLANK wrap, is treated as VBLANK.

## Test plan
- Reset, then run one frame with overscan=0:
  - exactly 1 newframe, visible at v=1 h=0;
  - 223 newlines;
  - 224 period_starts, each visible at h=21;
  - active high for exactly 256 dots per active line.
- Repeat with overscan=1: 238 newlines and 239 period_starts. Toggling overscan mid-frame has no effect until the next newframe.
- Write 0x3F at v=50 h=100 (ACTIVE):
  - pend=1 and size/bg_en unchanged through dot 277;
  - size=3 and bg_en=0xF visible at h=278;
  - pend=0.
- Write 0x21 then 0x72 during ACTIVE: only 0x72 is applied at line end. A write on the exact apply clk bypasses with pend=0.
- dot_en asserted every 4th clk with reg_wr pulses between enables: strobe widths equal one dot, and the counts match the full-rate run.
- Assert reset at v=100 h=150: outputs are 0 next clk. No strobes until the newframe at v=0 h=339.

Source files
------------

// File: rtl/mosaic_ctrl.sv
// PPU BG mosaic sequencer: decodes dot/line position into counter strobes and
// shadows the MOSAIC register so size/enable only change outside active display.
module mosaic_ctrl #(
  parameter logic [8:0] H_ACT_START  = 9'd22,
  parameter logic [8:0] H_ACT_END    = 9'd277,
  parameter logic [8:0] H_TOTAL      = 9'd340,
  parameter logic [8:0] V_ACT_START  = 9'd1,
  parameter logic [8:0] V_LAST_SHORT = 9'd224,
  parameter logic [8:0] V_LAST_LONG  = 9'd239
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic [8:0] h_ctr,
  input  logic [8:0] v_ctr,
  input  logic       overscan,
  input  logic       reg_wr,
  input  logic [7:0] reg_data,
  output logic       newframe,
  output logic       newline,
  output logic       period_start,
  output logic [3:0] size,
  output logic [3:0] bg_en,
  output logic       active,
  output logic       pend
);

  typedef enum logic [1:0] {
    VBLANK = 2'd0,
    HBLANK = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       v_last_q, v_last_d;
  logic       newframe_q, newframe_d;
  logic       newline_q, newline_d;
  logic       period_start_q, period_start_d;
  logic       active_q, active_d;
  logic       pend_q, pend_d;
  logic [7:0] pdata_q, pdata_d;
  logic [7:0] cfg_q, cfg_d;

  logic [8:0] v_last;
  logic       line_end;
  logic       frame_start;
  logic       in_lines;
  logic       apply;

  assign v_last      = v_last_q ? V_LAST_LONG : V_LAST_SHORT;
  assign line_end    = (h_ctr == H_TOTAL - 9'd1);
  assign frame_start = line_end && (v_ctr == V_ACT_START - 9'd1);
  assign in_lines    = (v_ctr >= V_ACT_START) && (v_ctr <= v_last);

  // Next state and strobe decode from the sampled dot position
  always_comb begin
    state_d        = state_q;
    v_last_d       = v_last_q;
    newframe_d     = 1'b0;
    newline_d      = 1'b0;
    period_start_d = 1'b0;
    if (frame_start) begin
      state_d    = HBLANK;
      v_last_d   = overscan;
      newframe_d = 1'b1;
    end else begin
      case (state_q)
        VBLANK: state_d = VBLANK;
        HBLANK: begin
          if (!in_lines) begin
            state_d = VBLANK;
          end else if (line_end && (v_ctr == v_last)) begin
            state_d = VBLANK;
          end else if (h_ctr == H_ACT_START - 9'd1) begin
            state_d = ACTIVE;
          end else begin
            state_d = HBLANK;
          end
          newline_d      = in_lines && line_end && (v_ctr < v_last);
          period_start_d = in_lines && (h_ctr == H_ACT_START - 9'd2);
        end
        ACTIVE: begin
          if (!in_lines) begin
            state_d = VBLANK;
          end else if (h_ctr == H_ACT_END) begin
            state_d = HBLANK;
          end else begin
            state_d = ACTIVE;
          end
        end
        default: state_d = VBLANK;
      endcase
    end
    active_d = (state_d == ACTIVE);
  end

  // Leaving ACTIVE counts as eligible, so a held write lands right after H_ACT_END
  assign apply = dot_en && pend_q && ((state_q != ACTIVE) || (state_d != ACTIVE));

  // Write capture and apply; a write on the apply clk bypasses the pending copy
  always_comb begin
    pdata_d = pdata_q;
    cfg_d   = cfg_q;
    pend_d  = pend_q;
    if (reg_wr) begin
      pdata_d = reg_data;
    end else begin
      pdata_d = pdata_q;
    end
    if (apply) begin
      cfg_d  = reg_wr ? reg_data : pdata_q;
      pend_d = 1'b0;
    end else if (reg_wr) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Dot-rate sequencing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= VBLANK;
      v_last_q       <= 1'b0;
      newframe_q     <= 1'b0;
      newline_q      <= 1'b0;
      period_start_q <= 1'b0;
      active_q       <= 1'b0;
    end else if (dot_en) begin
      state_q        <= state_d;
      v_last_q       <= v_last_d;
      newframe_q     <= newframe_d;
      newline_q      <= newline_d;
      period_start_q <= period_start_d;
      active_q       <= active_d;
    end
  end

  // Register-write shadow, runs on every clk
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      pdata_q <= 8'h00;
      cfg_q   <= 8'h00;
    end else begin
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      cfg_q   <= cfg_d;
    end
  end

  assign newframe     = newframe_q;
  assign newline      = newline_q;
  assign period_start = period_start_q;
  assign size         = cfg_q[7:4];
  assign bg_en        = cfg_q[3:0];
  assign active       = active_q;
  assign pend         = pend_q;

endmodule

// File: tb/tb_mosaic_ctrl.sv
// Self-checking bench for mosaic_ctrl: a raster generator with randomized writes,
// compared every clk against a position-window reference model.
module tb_mosaic_ctrl;

  logic       clk = 1'b0;
  logic       reset, dot_en, overscan, reg_wr;
  logic [8:0] h_ctr, v_ctr;
  logic [7:0] reg_data;
  logic       newframe, newline, period_start, active, pend;
  logic [3:0] size, bg_en;

  mosaic_ctrl dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .h_ctr(h_ctr), .v_ctr(v_ctr),
    .overscan(overscan), .reg_wr(reg_wr), .reg_data(reg_data),
    .newframe(newframe), .newline(newline), .period_start(period_start),
    .size(size), .bg_en(bg_en), .active(active), .pend(pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (v=%0d h=%0d t=%0t)", tag, obs, exp, v_ctr, h_ctr, $time);
    end
  endtask

  // Raster position presented to the DUT; compressed lines visit only these dots
  int hh = 0;
  int vv = 0;
  int comp_dots[15] = '{0, 1, 19, 20, 21, 22, 23, 100, 150, 276, 277, 278, 279, 338, 339};

  function automatic int next_comp(input int h);
    for (int i = 0; i < 15; i++) if (comp_dots[i] > h) return comp_dots[i];
    return 0;
  endfunction

  function automatic bit is_full(input int v);
    return (v == 1) || (v == 50) || (v == 224) || (v == 239);
  endfunction

  // Reference model: outputs derived from which window the sampled dot lies in
  bit       m_live = 1'b0;
  int       m_vlast = 224;
  bit       m_nf, m_nl, m_ps, m_act, m_pend;
  bit [7:0] m_cfg, m_pdata;

  task automatic model_update(input bit de, input bit rst, input bit wr, input logic [7:0] wd);
    bit apply;
    bit actl;
    apply = 1'b0;
    if (rst) begin
      {m_nf, m_nl, m_ps, m_act, m_pend, m_live} = 6'b0;
      m_cfg = 8'h00; m_pdata = 8'h00; m_vlast = 224;
    end else begin
      if (de) begin
        actl  = m_live && vv >= 1 && vv <= m_vlast;
        m_nf  = (vv == 0) && (hh == 339);
        m_nl  = m_live && (hh == 339) && vv >= 1 && vv < m_vlast;
        m_ps  = actl && (hh == 20);
        m_act = actl && hh >= 21 && hh <= 276;
        apply = m_pend && !(actl && hh >= 22 && hh <= 276);
        if (m_nf) begin
          m_live  = 1'b1;
          m_vlast = overscan ? 239 : 224;
        end else if (m_live && hh == 339 && vv == m_vlast) begin
          m_live = 1'b0;
        end
      end
      if (apply) begin
        m_cfg  = wr ? wd : m_pdata;
        m_pend = 1'b0;
      end else if (wr) begin
        m_pend = 1'b1;
      end
      if (wr) m_pdata = wd;
    end
  endtask

  function automatic logic [15:0] outvec();
    return {3'b000, newframe, newline, period_start, size, bg_en, active, pend};
  endfunction

  function automatic logic [15:0] modelvec();
    return {3'b000, m_nf, m_nl, m_ps, m_cfg, m_act, m_pend};
  endfunction

  int cpd = 1;
  int run[3] = '{0, 0, 0};

  task automatic step(input bit de, input bit rst, input bit wr, input logic [7:0] wd);
    logic [2:0] sv;
    dot_en = de; reset = rst; reg_wr = wr; reg_data = wd;
    h_ctr = 9'(hh); v_ctr = 9'(vv);
    @(posedge clk);
    model_update(de, rst, wr, wd);
    #1;
    check_eq("outputs", outvec(), modelvec());
    sv = {newframe, newline, period_start};
    for (int i = 0; i < 3; i++) begin
      if (sv[i]) run[i]++;
      else if (run[i] != 0) begin
        check_eq("strobe_width", 16'(run[i]), 16'(cpd));
        run[i] = 0;
      end
    end
  endtask

  // fid: 0 ovs=0 with directed writes, 1 ovs=1 with toggling, 2 quarter rate, 3 mid-frame reset, 4 partial
  task automatic run_pass(input int fid);
    int  clk_i, n_nf, n_nl, n_ps, post, act_cnt, fvlast, nh, nv;
    bit  done, quarter, after_rst, de, rst, wr;
    logic [7:0] wd, exp_cfg;
    clk_i = 0; n_nf = 0; n_nl = 0; n_ps = 0; post = 0; act_cnt = 0;
    done = 1'b0; after_rst = 1'b0;
    quarter = (fid == 2);
    fvlast  = (fid == 1) ? 239 : 224;
    cpd     = quarter ? 4 : 1;
    while (!done) begin
      de  = quarter ? (clk_i % 4 == 0) : 1'b1;
      rst = (fid == 3) && de && vv == 100 && hh == 150;
      wd  = 8'($urandom);
      if (quarter) wr = !de && ($urandom_range(0, 39) == 0);
      else if (fid == 0 && vv >= 40 && vv <= 80) wr = 1'b0;
      else wr = ($urandom_range(0, 149) == 0);
      if (fid == 0) begin
        if (vv == 50 && hh == 100) begin wr = 1'b1; wd = 8'h3F; end
        if (vv == 60 && hh == 100) begin wr = 1'b1; wd = 8'h21; end
        if (vv == 60 && hh == 150) begin wr = 1'b1; wd = 8'h72; end
        if (vv == 70 && hh == 100) begin wr = 1'b1; wd = 8'h11; end
        if (vv == 70 && hh == 277) begin wr = 1'b1; wd = 8'h5A; end
      end
      overscan = (fid == 1) ? ((vv >= 5 && vv <= 200) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      step(de, rst, wr, wd);
      clk_i++;
      if (rst) begin
        check_eq("reset_clears", outvec(), 16'h0000);
        after_rst = 1'b1;
      end
      if (de) begin
        if (hh == 339) begin
          nh = 0; nv = (vv == 240) ? 0 : vv + 1;
        end else begin
          nv = vv; nh = is_full(vv) ? hh + 1 : next_comp(hh);
        end
        if (nv != vv) begin
          if (fid <= 2 && is_full(vv))
            check_eq("active_dots", 16'(act_cnt), (vv >= 1 && vv <= fvlast) ? 16'd256 : 16'd0);
          act_cnt = 0;
          if (nv == 0) done = 1'b1;
        end
        hh = nh; vv = nv;
        if (active && is_full(vv)) act_cnt++;
        if (newframe) begin n_nf++; check_eq("nf_pos", 16'(vv * 400 + hh), 16'd400); end
        if (newline) n_nl++;
        if (period_start) begin n_ps++; check_eq("ps_pos", 16'(hh), 16'd21); end
        if (after_rst) post += int'(newframe) + int'(newline) + int'(period_start);
        if (fid == 0 && vv == 50 && hh == 277) check_eq("held_pend", {15'b0, pend}, 16'd1);
        if (fid == 0 && hh == 278 && (vv == 50 || vv == 60 || vv == 70)) begin
          exp_cfg = (vv == 50) ? 8'h3F : (vv == 60) ? 8'h72 : 8'h5A;
          check_eq("apply_cfg", {7'b0, pend, size, bg_en}, {8'b0, exp_cfg});
        end
        if (fid == 4 && vv == 3) done = 1'b1;
      end
    end
    if (fid <= 2) begin
      check_eq("newframe_cnt", 16'(n_nf), 16'd1);
      check_eq("newline_cnt", 16'(n_nl), 16'(fvlast - 1));
      check_eq("period_cnt", 16'(n_ps), 16'(fvlast));
    end else if (fid == 3) begin
      check_eq("quiet_after_rst", 16'(post), 16'd0);
    end else begin
      check_eq("newframe_cnt", 16'(n_nf), 16'd1);
    end
  endtask

  initial begin
    reset = 1'b1; dot_en = 1'b0; overscan = 1'b0; reg_wr = 1'b0; reg_data = 8'h00;
    h_ctr = 9'd0; v_ctr = 9'd0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("reset_state", outvec(), 16'h0000);
    for (int f = 0; f < 5; f++) run_pass(f);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
